if_fetch: RTL

Instruction-fetch stage sitting directly downstream of the next-PC logic: owns the architectural fetch PC register, issues requests on the SRAM-like instruction-memory port, buffers one returned instruction for the IF/ID boundary, and absorbs stalls, exception/eret flushes and branch redirects. It drives `PC` back into the next-PC logic and takes `NPC` from it.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/if_inst_buf.sv | 46 ++++
 rtl/if_fetch.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: boot/exception addresses, fetch FSM
// states and the payload held at the IF/ID boundary.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC   = 32'hBFC0_0000;
    localparam logic [XLEN-1:0] EXC_VECTOR = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2,
        FS_DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            adel;
    } fetch_entry_t;

endpackage

// File: rtl/if_inst_buf.sv
// Single-entry holding register for the fetched instruction presented to ID.
// Clear wins over load, load wins over consume.
module if_inst_buf
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic         consume_i,
    input  fetch_entry_t entry_i,
    output logic         valid_o,
    output fetch_entry_t entry_o
);

    logic         valid_q, valid_d;
    fetch_entry_t entry_q, entry_d;

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (clear_i) begin
            valid_d = 1'b0;
            entry_d = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            entry_d = entry_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o = valid_q;
    assign entry_o = entry_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives the SRAM-like
// instruction port and buffers one instruction for the IF/ID boundary.
module if_fetch #(
    parameter logic [cpu_pkg::XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [cpu_pkg::XLEN-1:0] NPC,
    input  logic                     PCWr,
    input  logic                     PC_Flush,
    input  logic                     IF_Flush,
    output logic [cpu_pkg::XLEN-1:0] PC,
    output logic                     inst_req,
    output logic [cpu_pkg::XLEN-1:0] inst_addr,
    input  logic                     inst_addr_ok,
    input  logic                     inst_data_ok,
    input  logic [cpu_pkg::XLEN-1:0] inst_rdata,
    output logic                     IF_valid,
    output logic [cpu_pkg::XLEN-1:0] IF_PC,
    output logic [cpu_pkg::XLEN-1:0] IF_Instr,
    output logic                     IF_AdEL
);

    import cpu_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic            redir_valid_q, redir_valid_d;

    logic            aligned_c;
    logic            req_c;
    logic            buf_load, buf_clear, buf_consume;
    logic            buf_valid;
    fetch_entry_t    buf_in, buf_out;

    assign aligned_c = (pc_q[1:0] == 2'b00);
    assign req_c     = (state_q == FS_REQ) && aligned_c;

    // Next-state, PC and redirect bookkeeping
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redir_pc_d    = redir_pc_q;
        redir_valid_d = redir_valid_q;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
        buf_consume   = 1'b0;
        buf_in        = '{pc: pc_q, instr: '0, adel: 1'b0};

        if (IF_Flush) begin
            pc_d          = NPC;
            redir_valid_d = 1'b0;
            buf_clear     = 1'b0 | 1'b1;
            case (state_q)
                // A request accepted in the flush cycle still owes a data beat
                FS_REQ:           state_d = (req_c && inst_addr_ok) ? FS_DROP : FS_REQ;
                FS_WAIT, FS_DROP: state_d = inst_data_ok ? FS_REQ : FS_DROP;
                default:          state_d = FS_REQ;
            endcase
        end else begin
            case (state_q)
                FS_REQ: begin
                    if (!aligned_c) begin
                        buf_load    = 1'b1;
                        buf_in.adel = 1'b1;
                        state_d     = FS_HOLD;
                    end else if (inst_addr_ok) begin
                        state_d = FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (inst_data_ok) begin
                        buf_load     = 1'b1;
                        buf_in.instr = inst_rdata;
                        state_d      = FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    if (PCWr) begin
                        buf_consume   = 1'b1;
                        state_d       = FS_REQ;
                        pc_d          = redir_valid_q ? redir_pc_q : NPC;
                        redir_valid_d = 1'b0;
                    end
                end
                FS_DROP: begin
                    if (inst_data_ok) begin
                        state_d = FS_REQ;
                    end
                end
                default: state_d = FS_REQ;
            endcase

            // Branch resolved before its delay slot arrived: remember the target
            if (PC_Flush && PCWr && (state_q != FS_HOLD)) begin
                redir_pc_d    = NPC;
                redir_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FS_REQ;
            pc_q          <= RESET_PC;
            redir_pc_q    <= '0;
            redir_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redir_pc_q    <= redir_pc_d;
            redir_valid_q <= redir_valid_d;
        end
    end

    if_inst_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .load_i    (buf_load),
        .clear_i   (buf_clear),
        .consume_i (buf_consume),
        .entry_i   (buf_in),
        .valid_o   (buf_valid),
        .entry_o   (buf_out)
    );

    assign PC        = pc_q;
    assign inst_req  = req_c;
    assign inst_addr = pc_q;
    assign IF_valid  = buf_valid;
    assign IF_PC     = buf_out.pc;
    assign IF_Instr  = buf_out.instr;
    assign IF_AdEL   = buf_out.adel;

endmodule
